cavlc_coeff_rebuild: RTL and testbench

CAVLC_COEFF_REBUILD -- requirements
Module: cavlc_coeff_rebuild

---
 rtl/cavlc_coeff_rebuild.sv | 68 ++++++
 tb/tb_cavlc_coeff_rebuild.sv | 134 +++++++++++++
 2 files changed

// File: rtl/cavlc_coeff_rebuild.sv
// cavlc_coeff_rebuild: places CAVLC level/run pairs back into a 4x4 block via zigzag scan
module cavlc_coeff_rebuild (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [4:0]   total_coeffs,
  input  logic [3:0]   total_zeros,
  input  logic         coef_valid,
  output logic         coef_ready,
  input  logic [14:0]  coef_level,
  input  logic [3:0]   coef_run,
  output logic [239:0] blk_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         err
);
  typedef enum logic [1:0] {IDLE, FILL, OUT} state_t;
  localparam logic [63:0] ZZ = 64'hFEB7_ADC9_6325_8410;
  state_t state;
  logic [4:0] cnt, ptr;
  logic [3:0] zl, run, raster;
  logic [5:0] sum;
  logic bad;
  always_comb begin
    sum = {1'b0, total_coeffs} + {2'b0, total_zeros};
    bad = total_coeffs != 5'd0 && (total_coeffs > 5'd16 || sum > 6'd16);
    run = coef_run > zl ? zl : coef_run;
    raster = ZZ[4*ptr[3:0] +: 4];
  end
  assign coef_ready = state == FILL;
  assign out_valid = state == OUT;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      blk_out <= '0;
      cnt <= '0;
      zl <= '0;
      ptr <= '0;
      err <= 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        blk_out <= '0;
        cnt <= total_coeffs;
        zl <= total_zeros;
        ptr <= sum[4:0] - 5'd1;
        err <= bad;
        state <= (total_coeffs == 5'd0 || bad) ? OUT : FILL;
      end
    end else if (state == FILL) begin
      if (coef_valid) begin
        blk_out[15*raster +: 15] <= coef_level;
        cnt <= cnt - 5'd1;
        if (cnt == 5'd1) begin
          state <= OUT;
          err <= err | (ptr != {1'b0, zl}) | (coef_level == 15'd0);
        end else begin
          ptr <= ptr - 5'd1 - {1'b0, run};
          zl <= zl - run;
          err <= err | (coef_run > zl) | (coef_level == 15'd0);
        end
      end
    end else if (out_ready) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_cavlc_coeff_rebuild.sv
// tb_cavlc_coeff_rebuild: directed self-checking bench for cavlc_coeff_rebuild
module tb_cavlc_coeff_rebuild;
  logic clk = 0, rst = 1, start = 0, coef_valid = 0, out_ready = 0;
  logic [4:0] total_coeffs = 0;
  logic [3:0] total_zeros = 0, coef_run = 0;
  logic [14:0] coef_level = 0;
  logic coef_ready, out_valid, busy, err;
  logic [239:0] blk_out, exp_blk, held;
  int errors = 0, checks = 0;
  int zz[16] = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};
  always #5 clk = ~clk;
  cavlc_coeff_rebuild dut (
    .clk(clk), .rst(rst), .start(start), .total_coeffs(total_coeffs),
    .total_zeros(total_zeros), .coef_valid(coef_valid), .coef_ready(coef_ready),
    .coef_level(coef_level), .coef_run(coef_run), .blk_out(blk_out),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .err(err)
  );
  task automatic chk(input string tag, input logic [239:0] obs, input logic [239:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic begin_blk(input logic [4:0] tc, input logic [3:0] tz);
    start = 1; total_coeffs = tc; total_zeros = tz;
    tick();
    start = 0;
  endtask
  task automatic pair(input logic [14:0] l, input logic [3:0] r);
    chk("coef_ready_in_fill", coef_ready, 1);
    coef_valid = 1; coef_level = l; coef_run = r;
    tick();
    coef_valid = 0;
  endtask
  task automatic release_blk();
    out_ready = 1;
    tick();
    out_ready = 0;
    chk("idle_after_accept", {busy, out_valid}, 0);
  endtask
  initial begin
    tick(); tick();
    rst = 0;
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_coef_ready", coef_ready, 0);
    chk("rst_err", err, 0);
    chk("rst_blk", blk_out, 0);
    // tc=3 tz=2: scan4 -> raster5, scan2 -> raster4, scan0 -> raster0
    begin_blk(3, 2);
    chk("t1_busy", busy, 1);
    pair(15'd5, 1); pair(15'h7FFE, 1); pair(15'd1, 0);
    chk("t1_out_valid", out_valid, 1);
    chk("t1_err", err, 0);
    exp_blk = '0;
    exp_blk[15*5 +: 15] = 15'd5; exp_blk[15*4 +: 15] = 15'h7FFE; exp_blk[0 +: 15] = 15'd1;
    chk("t1_blk", blk_out, exp_blk);
    release_blk();
    chk("t1_blk_held", blk_out, exp_blk);
    // full block: level i lands at scan 16-i
    begin_blk(16, 0);
    for (int i = 1; i <= 16; i++) pair(15'(i), 0);
    chk("t2_out_valid", out_valid, 1);
    chk("t2_err", err, 0);
    exp_blk = '0;
    for (int k = 0; k < 16; k++) exp_blk[15*zz[k] +: 15] = 15'(16 - k);
    chk("t2_blk", blk_out, exp_blk);
    release_blk();
    // empty block
    begin_blk(0, 0);
    chk("t3_out_valid", out_valid, 1);
    chk("t3_err", err, 0);
    chk("t3_blk", blk_out, 0);
    release_blk();
    // too many coefficients plus zeros
    begin_blk(10, 9);
    chk("t4_out_valid", out_valid, 1);
    chk("t4_err", err, 1);
    chk("t4_blk", blk_out, 0);
    chk("t4_coef_ready", coef_ready, 0);
    release_blk();
    // run larger than remaining zeros is clamped
    begin_blk(2, 1);
    pair(15'd7, 3); pair(15'd3, 0);
    exp_blk = '0;
    exp_blk[15*4 +: 15] = 15'd7; exp_blk[0 +: 15] = 15'd3;
    chk("t5_out_valid", out_valid, 1);
    chk("t5_err", err, 1);
    chk("t5_blk", blk_out, exp_blk);
    release_blk();
    // zero level flags an error
    begin_blk(1, 0);
    pair(15'd0, 0);
    chk("t6_out_valid", out_valid, 1);
    chk("t6_err", err, 1);
    release_blk();
    // reset mid-block
    begin_blk(4, 0);
    pair(15'd1, 0); pair(15'd2, 0);
    rst = 1;
    tick();
    rst = 0;
    chk("t7_busy", busy, 0);
    chk("t7_blk", blk_out, 0);
    chk("t7_coef_ready", coef_ready, 0);
    chk("t7_out_valid", out_valid, 0);
    tick();
    chk("t7_no_out_valid", out_valid, 0);
    begin_blk(1, 0);
    pair(15'h7FF9, 0);
    chk("t7_new_out_valid", out_valid, 1);
    chk("t7_new_err", err, 0);
    chk("t7_new_blk", blk_out, {225'd0, 15'h7FF9});
    // stall in OUT with stray start and coef_valid
    held = blk_out;
    for (int i = 0; i < 5; i++) begin
      start = 1; total_coeffs = 3; coef_valid = 1; coef_level = 15'd9;
      tick();
      chk("t8_out_valid", out_valid, 1);
      chk("t8_coef_ready", coef_ready, 0);
      chk("t8_blk", blk_out, held);
    end
    start = 0; coef_valid = 0;
    release_blk();
    chk("t8_blk_after", blk_out, held);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
